// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer writer: state encoding,
// default geometry/pixel width and a constant-foldable clog2 helper.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_WRITE     = 2'd1,
    ST_FULL      = 2'd2
  } fb_state_e;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_PIX_W    = 12;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level followed by a
// registered rising-edge detector producing a one-cycle pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Resynchronize the foreign level and register its rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Double-buffered frame capture: writes a stream of pixels into one BRAM
// bank per frame, swapping banks only on complete frames so the reader
// always sees the most recent whole frame.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              vsync_async,
  input  logic              capture_en,
  output logic              bram_we,
  output logic [ADDR_W:0]   bram_addr,
  output logic [PIX_W-1:0]  bram_data,
  output logic              rd_bank,
  output logic              rd_valid,
  output logic              frame_done,
  output logic              short_frame,
  output logic              overflow
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIX - 1);

  // Pixel index must be wide enough to address a whole frame.
  if (ADDR_W < clog2(FRAME_PIX)) begin : g_addr_w_check
    $error("frame_buffer_writer: ADDR_W too small for H_ACTIVE*V_ACTIVE");
  end

  fb_state_e          state_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W-1:0]  idx_d;
  logic               wr_bank_q;
  logic               rd_bank_q;
  logic               rd_valid_q;
  logic               bram_we_q;
  logic [ADDR_W:0]    bram_addr_q;
  logic [PIX_W-1:0]   bram_data_q;
  logic               frame_done_q;
  logic               short_frame_q;
  logic               overflow_q;
  logic               sync_pulse;

  sync_edge_detect u_vsync (
    .clk     (clk),
    .rst     (rst),
    .async_i (vsync_async),
    .pulse_o (sync_pulse)
  );

  assign idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Capture FSM with registered BRAM port and status pulses; a sync pulse
  // always takes priority over a pixel arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_SYNC;
      idx_q         <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_data_q   <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      bram_we_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      overflow_q    <= 1'b0;
      case (state_q)
        ST_WAIT_SYNC: begin
          if (sync_pulse && capture_en) begin
            state_q <= ST_WRITE;
            idx_q   <= '0;
          end
        end
        ST_WRITE: begin
          if (sync_pulse) begin
            // Frame cut short: restart in the same bank, reader untouched.
            short_frame_q <= 1'b1;
            idx_q         <= '0;
            state_q       <= capture_en ? ST_WRITE : ST_WAIT_SYNC;
          end else if (pix_valid) begin
            bram_we_q   <= 1'b1;
            bram_addr_q <= {wr_bank_q, idx_q};
            bram_data_q <= pix_data;
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              rd_bank_q    <= wr_bank_q;
              rd_valid_q   <= 1'b1;
              wr_bank_q    <= ~wr_bank_q;
              idx_q        <= '0;
              state_q      <= ST_FULL;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        ST_FULL: begin
          if (sync_pulse) begin
            idx_q   <= '0;
            state_q <= capture_en ? ST_WRITE : ST_WAIT_SYNC;
          end else if (pix_valid) begin
            overflow_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_WAIT_SYNC;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bram_we     = bram_we_q;
  assign bram_addr   = bram_addr_q;
  assign bram_data   = bram_data_q;
  assign rd_bank     = rd_bank_q;
  assign rd_valid    = rd_valid_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer (4x2 frame). A behavioural model
// predicts every cycle's outputs when stimulus is applied; a monitor pops
// and compares after each clock edge.
module tb_frame_buffer_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FP = H * V;
  localparam int PW = 12;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          vsync_async;
  logic          capture_en;
  logic          bram_we;
  logic [AW:0]   bram_addr;
  logic [PW-1:0] bram_data;
  logic          rd_bank;
  logic          rd_valid;
  logic          frame_done;
  logic          short_frame;
  logic          overflow;

  frame_buffer_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIX_W    (PW),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .vsync_async (vsync_async),
    .capture_en  (capture_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_data   (bram_data),
    .rd_bank     (rd_bank),
    .rd_valid    (rd_valid),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW:0]   addr;
    logic [PW-1:0] data;
    logic          done;
    logic          shrt;
    logic          ovf;
    logic          rdb;
    logic          rdv;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: mode 0 = waiting for sync, 1 = capturing, 2 = frame held.
  int            m_mode;
  int            m_count;
  bit            m_bank;
  bit            m_rdb;
  bit            m_rdv;
  logic [AW:0]   m_addr;
  logic [PW-1:0] m_data;
  bit            vs_hist [1:4];   // vs_hist[k] = vsync level k cycles ago

  bit cur_vs = 1'b0;
  bit cur_ce = 1'b1;

  task automatic model_reset();
    m_mode  = 0;
    m_count = 0;
    m_bank  = 1'b0;
    m_rdb   = 1'b0;
    m_rdv   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    for (int k = 1; k <= 4; k++) vs_hist[k] = 1'b0;
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic drive(input bit r, input bit pv, input logic [PW-1:0] pd,
                       input bit vs, input bit ce);
    exp_t e;
    bit   sync;
    @(negedge clk);
    rst         = r;
    pix_valid   = pv;
    pix_data    = pd;
    vsync_async = vs;
    capture_en  = ce;
    if (r) begin
      model_reset();
    end else begin
      // A rising vsync level becomes visible to the capture logic 3 cycles later.
      sync = vs_hist[3] & ~vs_hist[4];
      vs_hist[4] = vs_hist[3];
      vs_hist[3] = vs_hist[2];
      vs_hist[2] = vs_hist[1];
      vs_hist[1] = vs;
    end
    e.we = 1'b0; e.done = 1'b0; e.shrt = 1'b0; e.ovf = 1'b0;
    if (!r) begin
      if (sync) begin
        if (m_mode == 1) e.shrt = 1'b1;
        if (ce) m_mode = 1;
        else    m_mode = 0;
        m_count = 0;
      end else if (pv && m_mode == 1) begin
        e.we   = 1'b1;
        m_addr = {m_bank, AW'(m_count)};
        m_data = pd;
        m_count++;
        if (m_count == FP) begin
          e.done  = 1'b1;
          m_rdb   = m_bank;
          m_rdv   = 1'b1;
          m_bank  = ~m_bank;
          m_mode  = 2;
          m_count = 0;
        end
      end else if (pv && m_mode == 2) begin
        e.ovf = 1'b1;
      end
    end
    e.addr = m_addr;
    e.data = m_data;
    e.rdb  = m_rdb;
    e.rdv  = m_rdv;
    exp_q.push_back(e);
  endtask

  task automatic px(input bit pv, input logic [PW-1:0] d);
    drive(1'b0, pv, d, cur_vs, cur_ce);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'b0, 12'h000);
  endtask

  task automatic vsync_edge();
    cur_vs = 1'b1;
    idle(4);
    cur_vs = 1'b0;
    idle(1);
  endtask

  task automatic pixels(input int n, input logic [PW-1:0] base);
    for (int i = 0; i < n; i++) px(1'b1, base + PW'(i));
  endtask

  // Monitor: compare DUT outputs against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bram_we !== e.we || bram_addr !== e.addr || bram_data !== e.data ||
            frame_done !== e.done || short_frame !== e.shrt ||
            overflow !== e.ovf || rd_bank !== e.rdb || rd_valid !== e.rdv) begin
          fails++;
          $display("FAIL cycle_outputs t=%0t got we=%0b addr=%0h data=%0h done=%0b short=%0b ovf=%0b rdb=%0b rdv=%0b required we=%0b addr=%0h data=%0h done=%0b short=%0b ovf=%0b rdb=%0b rdv=%0b",
                   $time, bram_we, bram_addr, bram_data, frame_done, short_frame,
                   overflow, rd_bank, rd_valid, e.we, e.addr, e.data, e.done,
                   e.shrt, e.ovf, e.rdb, e.rdv);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_data    = '0;
    vsync_async = 1'b0;
    capture_en  = 1'b1;
    model_reset();

    // Reset state.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
    idle(2);

    // Full frame into bank 0.
    vsync_edge();
    pixels(FP, 12'h001);

    // Overflow while full, then a frame into bank 1.
    pixels(3, 12'h0A0);
    vsync_edge();
    pixels(FP, 12'h101);

    // Short frame: 5 pixels, sync, then a complete frame in the same bank.
    vsync_edge();
    pixels(5, 12'h200);
    vsync_edge();
    pixels(FP, 12'h210);

    // Capture disabled mid-frame: frame completes, next sync parks the writer.
    vsync_edge();
    pixels(3, 12'h300);
    cur_ce = 1'b0;
    pixels(5, 12'h303);
    vsync_edge();
    pixels(4, 12'h310);
    cur_ce = 1'b1;

    // Sync coincident with a pixel: that pixel is dropped without overflow.
    cur_vs = 1'b1;
    pixels(6, 12'h400);
    cur_vs = 1'b0;
    pixels(FP, 12'h410);

    // Reset mid-frame, then a clean frame into bank 0.
    vsync_edge();
    pixels(4, 12'h500);
    drive(1'b1, 1'b1, 12'h5FF, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
    idle(1);
    vsync_edge();
    pixels(FP, 12'h601);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) cur_vs = ~cur_vs;
      if ($urandom_range(0, 59) == 0) cur_ce = ($urandom_range(0, 3) != 0);
      drive(r, ($urandom_range(0, 3) != 0), PW'($urandom), cur_vs, cur_ce);
    end

    idle(2);
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
